// File: rtl/wb_write_queue.sv
// wb_write_queue
//   Drives the register-file write port from two sources. ALU results (at most one
//   per cycle) always win the write slot. Load data coming back from memory goes into
//   a DEPTH-entry FIFO and is written when the ALU leaves the slot free. If a non-empty
//   FIFO is not drained for STARVE_LIMIT cycles, the ALU is held off for one cycle so
//   the head load can be written. Decode can look up writes that are still pending
//   (the registered write port, then queued loads, then the ALU input of this cycle).
//
// Ports
//   CLK, RESET                      clock (rising edge), async active-high reset
//   alu_valid/alu_ready             ALU result handshake
//   alu_rd, alu_data                ALU destination register and result
//   mem_valid/mem_ready             load data handshake
//   mem_rd, mem_data                load destination register and data
//   RegWrite, Write_register,
//   Write_Data                      registered register-file write port
//   byp_addr_1/2                    bypass lookup addresses
//   byp_hit_1/2, byp_data_1/2       bypass result (data is 0 on a miss)
//   q_count                         FIFO occupancy, valid and invalidated entries

module wb_write_queue #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_rd,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        Write_register,
    output logic [DATA_W-1:0]        Write_Data,
    input  logic [ADDR_W-1:0]        byp_addr_1,
    input  logic [ADDR_W-1:0]        byp_addr_2,
    output logic                     byp_hit_1,
    output logic                     byp_hit_2,
    output logic [DATA_W-1:0]        byp_data_1,
    output logic [DATA_W-1:0]        byp_data_2,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    // FIFO storage; ent_ok_r cleared means the entry was overwritten by a younger ALU write
    logic [ADDR_W-1:0] ent_rd_r   [DEPTH];
    logic [DATA_W-1:0] ent_data_r [DEPTH];
    logic [DEPTH-1:0]  ent_ok_r;
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic [STV_W-1:0]  starve_r;

    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_rd_r;
    logic [DATA_W-1:0] wr_data_r;

    logic              empty_s;
    logic              head_ok_s;
    logic              alu_acc_s;
    logic              alu_wr_s;
    logic              mem_acc_s;
    logic              pop_s;
    logic              head_wr_s;
    logic              push_s;
    logic [DEPTH-1:0]  ok_nxt_s;
    logic [STV_W-1:0]  starve_nxt_s;

    logic [PTR_W-1:0]  slot_s  [DEPTH];
    logic [DEPTH-1:0]  live_s;
    logic [ADDR_W-1:0] byp_addr_s [2];
    logic [1:0]        byp_hit_s;
    logic [DATA_W-1:0] byp_data_s [2];

    // The ALU is held off only in the single cycle the starvation count sits at its limit
    assign alu_ready      = (starve_r != STARVE_MAX);
    assign mem_ready      = (count_r < DEPTH_C);
    assign q_count        = count_r;
    assign RegWrite       = wr_en_r;
    assign Write_register = wr_rd_r;
    assign Write_Data     = wr_data_r;

    assign byp_addr_s[0] = byp_addr_1;
    assign byp_addr_s[1] = byp_addr_2;
    assign byp_hit_1     = byp_hit_s[0];
    assign byp_hit_2     = byp_hit_s[1];
    assign byp_data_1    = byp_data_s[0];
    assign byp_data_2    = byp_data_s[1];

    // Per-cycle handshake, write-slot selection, kill of older same-rd loads and starvation
    always_comb begin
        empty_s   = (count_r == {CNT_W{1'b0}});
        head_ok_s = ent_ok_r[head_r];
        alu_acc_s = alu_valid & alu_ready;
        alu_wr_s  = alu_acc_s & (alu_rd != {ADDR_W{1'b0}});
        mem_acc_s = mem_valid & mem_ready;
        // An invalidated head is still popped, it just produces no write
        pop_s     = ~empty_s & ~alu_wr_s;
        head_wr_s = pop_s & head_ok_s;
        // Loads to r0, or shadowed by the same-cycle ALU write, are accepted and dropped
        push_s    = mem_acc_s & (mem_rd != {ADDR_W{1'b0}})
                  & ~(alu_wr_s & (alu_rd == mem_rd));
        ok_nxt_s  = ent_ok_r;
        for (int i = 0; i < DEPTH; i++) begin
            ok_nxt_s[i] = ent_ok_r[i] & ~(alu_wr_s & (ent_rd_r[i] == alu_rd));
        end
        ok_nxt_s[tail_r] = ok_nxt_s[tail_r] | push_s;
        starve_nxt_s = (empty_s | pop_s) ? {STV_W{1'b0}}
                     : (head_ok_s ? (starve_r + STV_W'(1'b1)) : starve_r);
    end

    // Queue positions in age order (k=0 is the oldest) and which of them hold a live write
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            slot_s[k] = head_r + PTR_W'(k);
            live_s[k] = (CNT_W'(k) < count_r) & ent_ok_r[slot_s[k]];
        end
    end

    // Bypass lookup; later assignments override earlier ones, so sources are visited from
    // lowest priority (ALU input) through queued loads oldest-to-youngest to the write port
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            byp_hit_s[p]  = alu_acc_s & (alu_rd == byp_addr_s[p]);
            byp_data_s[p] = alu_data;
            for (int k = 0; k < DEPTH; k++) begin
                byp_data_s[p] = (live_s[k] & (ent_rd_r[slot_s[k]] == byp_addr_s[p]))
                              ? ent_data_r[slot_s[k]] : byp_data_s[p];
                byp_hit_s[p]  = byp_hit_s[p]
                              | (live_s[k] & (ent_rd_r[slot_s[k]] == byp_addr_s[p]));
            end
            byp_data_s[p] = (wr_en_r & (wr_rd_r == byp_addr_s[p])) ? wr_data_r : byp_data_s[p];
            byp_hit_s[p]  = byp_hit_s[p] | (wr_en_r & (wr_rd_r == byp_addr_s[p]));
            byp_hit_s[p]  = byp_hit_s[p] & (byp_addr_s[p] != {ADDR_W{1'b0}});
            byp_data_s[p] = byp_hit_s[p] ? byp_data_s[p] : {DATA_W{1'b0}};
        end
    end

    // FIFO storage, pointers, occupancy and starvation counter
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head_r   <= {PTR_W{1'b0}};
            tail_r   <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            starve_r <= {STV_W{1'b0}};
            ent_ok_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_r[i]   <= {ADDR_W{1'b0}};
                ent_data_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            head_r   <= head_r + PTR_W'(pop_s);
            tail_r   <= tail_r + PTR_W'(push_s);
            count_r  <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
            starve_r <= starve_nxt_s;
            ent_ok_r <= ok_nxt_s;
            if (push_s) begin
                ent_rd_r[tail_r]   <= mem_rd;
                ent_data_r[tail_r] <= mem_data;
            end
        end
    end

    // Registered write port: one write per cycle, ALU result first, else a valid FIFO head
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_en_r   <= 1'b0;
            wr_rd_r   <= {ADDR_W{1'b0}};
            wr_data_r <= {DATA_W{1'b0}};
        end else begin
            wr_en_r <= alu_wr_s | head_wr_s;
            if (alu_wr_s) begin
                wr_rd_r   <= alu_rd;
                wr_data_r <= alu_data;
            end else if (head_wr_s) begin
                wr_rd_r   <= ent_rd_r[head_r];
                wr_data_r <= ent_data_r[head_r];
            end else begin
                wr_rd_r   <= wr_rd_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: a queue-based reference model checked every
// cycle on the falling edge, plus directed scenarios with hand-computed expectations.

module tb_wb_write_queue;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic        CLK;
    logic        RESET;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_Data;
    logic [4:0]  byp_addr_1;
    logic [4:0]  byp_addr_2;
    logic        byp_hit_1;
    logic        byp_hit_2;
    logic [31:0] byp_data_1;
    logic [31:0] byp_data_2;
    logic [2:0]  q_count;

    wb_write_queue #(
        .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .DATA_W(32), .ADDR_W(5)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .RegWrite(RegWrite), .Write_register(Write_register), .Write_Data(Write_Data),
        .byp_addr_1(byp_addr_1), .byp_addr_2(byp_addr_2),
        .byp_hit_1(byp_hit_1), .byp_hit_2(byp_hit_2),
        .byp_data_1(byp_data_1), .byp_data_2(byp_data_2),
        .q_count(q_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int n_writes   = 0;
    int aaaa_seen  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          ok;
    } ent_t;

    ent_t        mq[$];
    int          m_starve = 0;
    bit          m_we     = 1'b0;
    logic [4:0]  m_wrd    = 5'd0;
    logic [31:0] m_wdata  = 32'd0;

    function automatic void m_lookup(input logic [4:0] a, output bit hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'd0;
        if (a == 5'd0) return;
        if (m_we && m_wrd == a) begin
            hit = 1'b1; d = m_wdata; return;
        end
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].ok && mq[i].rd == a) begin
                hit = 1'b1; d = mq[i].data; return;
            end
        end
        if (alu_valid && (m_starve != STARVE_LIMIT) && alu_rd == a) begin
            hit = 1'b1; d = alu_data;
        end
    endfunction

    initial begin
        bit          h;
        logic [31:0] d;
        bit          acc_a, w_a, acc_m, pre_empty, head_ok, popped, n_we;
        logic [4:0]  n_wrd;
        logic [31:0] n_wdata;
        ent_t        e;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                mq.delete();
                m_starve = 0;
                m_we     = 1'b0;
                m_wrd    = 5'd0;
                m_wdata  = 32'd0;
            end
            if (RegWrite) n_writes++;
            if (RegWrite && Write_Data == 32'h0000AAAA) aaaa_seen++;
            chk("m_RegWrite", 32'(RegWrite), 32'(m_we));
            if (m_we) begin
                chk("m_Write_register", 32'(Write_register), 32'(m_wrd));
                chk("m_Write_Data", Write_Data, m_wdata);
            end
            chk("m_alu_ready", 32'(alu_ready), 32'(m_starve != STARVE_LIMIT));
            chk("m_mem_ready", 32'(mem_ready), 32'(mq.size() < DEPTH));
            chk("m_q_count", 32'(q_count), 32'(mq.size()));
            m_lookup(byp_addr_1, h, d);
            chk("m_byp_hit_1", 32'(byp_hit_1), 32'(h));
            chk("m_byp_data_1", byp_data_1, d);
            m_lookup(byp_addr_2, h, d);
            chk("m_byp_hit_2", 32'(byp_hit_2), 32'(h));
            chk("m_byp_data_2", byp_data_2, d);

            if (!RESET) begin
                acc_a     = alu_valid && (m_starve != STARVE_LIMIT);
                w_a       = acc_a && (alu_rd != 5'd0);
                acc_m     = mem_valid && (mq.size() < DEPTH);
                pre_empty = (mq.size() == 0);
                head_ok   = !pre_empty && mq[0].ok;
                popped    = 1'b0;
                n_we      = 1'b0;
                n_wrd     = 5'd0;
                n_wdata   = 32'd0;
                if (w_a) begin
                    n_we = 1'b1; n_wrd = alu_rd; n_wdata = alu_data;
                    foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].ok = 1'b0;
                end else if (!pre_empty) begin
                    e = mq.pop_front();
                    popped = 1'b1;
                    if (e.ok) begin
                        n_we = 1'b1; n_wrd = e.rd; n_wdata = e.data;
                    end
                end
                if (pre_empty || popped) m_starve = 0;
                else if (head_ok) m_starve++;
                if (acc_m && mem_rd != 5'd0 && !(w_a && alu_rd == mem_rd))
                    mq.push_back('{rd: mem_rd, data: mem_data, ok: 1'b1});
                m_we = n_we;
                if (n_we) begin
                    m_wrd   = n_wrd;
                    m_wdata = n_wdata;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    endtask

    initial begin
        int ld, arn, stall_at, wr_before;
        RESET = 1'b1;
        idle_inputs();
        byp_addr_1 = 5'd0; byp_addr_2 = 5'd0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_RegWrite", 32'(RegWrite), 32'd0);
        chk("rst_Write_register", 32'(Write_register), 32'd0);
        chk("rst_Write_Data", Write_Data, 32'd0);
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        RESET = 1'b0;
        cyc();

        // Single ALU write, FIFO idle
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h00001234;
        cyc();
        idle_inputs();
        chk("alu_RegWrite", 32'(RegWrite), 32'd1);
        chk("alu_Write_register", 32'(Write_register), 32'd8);
        chk("alu_Write_Data", Write_Data, 32'h00001234);
        cyc();
        chk("alu_RegWrite_drop", 32'(RegWrite), 32'd0);

        // Bypass of a queued load
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'h00000055;
        cyc();
        idle_inputs();
        byp_addr_1 = 5'd10; byp_addr_2 = 5'd0;
        #1;
        chk("byp_q_count", 32'(q_count), 32'd1);
        chk("byp_hit_1", 32'(byp_hit_1), 32'd1);
        chk("byp_data_1", byp_data_1, 32'h00000055);
        chk("byp_hit_2_r0", 32'(byp_hit_2), 32'd0);
        cyc();
        chk("ld_RegWrite", 32'(RegWrite), 32'd1);
        chk("ld_Write_register", 32'(Write_register), 32'd10);
        chk("ld_Write_Data", Write_Data, 32'h00000055);
        chk("ld_q_count", 32'(q_count), 32'd0);
        byp_addr_1 = 5'd0;
        cyc();

        // Younger ALU write kills the queued load to the same register
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h0000AAAA;
        cyc();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000BBBB;
        byp_addr_1 = 5'd9;
        #1;
        chk("kill_byp_fifo_over_alu", byp_data_1, 32'h0000AAAA);
        cyc();
        idle_inputs();
        #1;
        chk("kill_RegWrite", 32'(RegWrite), 32'd1);
        chk("kill_Write_register", 32'(Write_register), 32'd9);
        chk("kill_Write_Data", Write_Data, 32'h0000BBBB);
        chk("kill_q_count", 32'(q_count), 32'd1);
        chk("kill_byp_port", byp_data_1, 32'h0000BBBB);
        cyc();
        chk("kill_no_write", 32'(RegWrite), 32'd0);
        chk("kill_drained", 32'(q_count), 32'd0);
        byp_addr_1 = 5'd0;
        cyc();
        chk("kill_aaaa_never", 32'(aaaa_seen), 32'd0);

        // Register 0 from both sources in the same cycle
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h00000077;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h00000066;
        #1;
        chk("r0_alu_ready", 32'(alu_ready), 32'd1);
        chk("r0_mem_ready", 32'(mem_ready), 32'd1);
        cyc();
        idle_inputs();
        chk("r0_RegWrite", 32'(RegWrite), 32'd0);
        chk("r0_q_count", 32'(q_count), 32'd0);
        cyc();

        // Back-to-back ALU traffic starves the FIFO until the one-cycle ALU stall
        ld = 0; arn = 1; stall_at = -1;
        byp_addr_1 = 5'd20;
        for (int k = 0; k < 16; k++) begin
            alu_valid  = 1'b1;
            alu_rd     = 5'(arn);
            alu_data   = 32'h00000100 + 32'(arn);
            byp_addr_2 = 5'(arn);
            mem_valid  = (ld < 5);
            mem_rd     = 5'(20 + ld);
            mem_data   = 32'h00002000 + 32'(ld);
            #1;
            if (k == 4) begin
                chk("full_q_count", 32'(q_count), 32'd4);
                chk("full_mem_ready", 32'(mem_ready), 32'd0);
            end
            if (k == 10) begin
                chk("starve_RegWrite", 32'(RegWrite), 32'd1);
                chk("starve_Write_register", 32'(Write_register), 32'd20);
                chk("starve_Write_Data", Write_Data, 32'h00002000);
            end
            if (!alu_ready && stall_at < 0) stall_at = k;
            if (alu_ready) arn++;
            if (mem_valid && mem_ready) ld++;
            cyc();
        end
        chk("starve_stall_cycle", 32'(stall_at), 32'd9);
        chk("starve_loads_accepted", 32'(ld), 32'd5);
        idle_inputs();
        byp_addr_1 = 5'd0; byp_addr_2 = 5'd0;
        repeat (8) cyc();
        chk("starve_drained", 32'(q_count), 32'd0);

        // Reset mid-stream with three loads queued
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(k + 1); alu_data = 32'h00000500 + 32'(k);
            mem_valid = 1'b1; mem_rd = 5'(11 + k); mem_data = 32'h00003000 + 32'(k);
            cyc();
        end
        mem_valid = 1'b0;
        chk("pre_rst_q_count", 32'(q_count), 32'd3);
        #2;
        RESET = 1'b1;
        #1;
        chk("mid_rst_q_count", 32'(q_count), 32'd0);
        chk("mid_rst_RegWrite", 32'(RegWrite), 32'd0);
        chk("mid_rst_mem_ready", 32'(mem_ready), 32'd1);
        idle_inputs();
        wr_before = n_writes;
        cyc();
        RESET = 1'b0;
        repeat (6) cyc();
        chk("rst_no_stale_writes", 32'(n_writes - wr_before), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
